plab4_net_router_input_ctrl_arb_tdm: RTL and testbench

Parametrised successor to the two-domain separable input-control arbiter in the plab4 ring router. It routes and arbitrates requests from `p_num_domains` per-domain input buffers onto one 3-port switch-allocator request vector. Domain selection is deterministic: strict time-division slots, or work-conserving round-robin with a request lock. Grants are steered back only to the owning domain. The block sits between the per-domain input queues and the router's output switch allocator.

---
 rtl/plab4_net_router_input_ctrl_arb_tdm.sv | 137 +++++++++++++
 tb/tb_plab4_net_router_input_ctrl_arb_tdm.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_router_input_ctrl_arb_tdm.sv
// Per-domain input-control arbiter: picks one domain's head flit each cycle and
// routes it onto the 3-port switch-allocator request vector (TDM or RR-with-lock).
//
// state              | meaning
// tdm                | mode 0: owner = cur_dom, slot_cnt free-runs, cur_dom steps at wrap
// idle   (!lock_vld) | mode 1: owner = first valid domain searching up from rr_ptr
// locked (lock_vld)  | mode 1: owner pinned to lock_dom until it fires or drops val
module plab4_net_router_input_ctrl_arb_tdm #(
  parameter int         p_router_id    = 0,
  parameter int         p_num_routers  = 8,
  parameter int         p_num_domains  = 2,
  parameter int         p_slot_cycles  = 4,
  parameter int         p_mode         = 0,
  parameter logic [2:0] p_default_reqs = 3'b010,
  localparam int        c_dest_nbits   = $clog2(p_num_routers),
  localparam int        c_dom_nbits    = (p_num_domains > 2) ? $clog2(p_num_domains) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [p_num_domains*c_dest_nbits-1:0] dest,
  input  logic [p_num_domains-1:0]             in_val,
  output logic [p_num_domains-1:0]             in_rdy,
  output logic [2:0]                           reqs,
  input  logic [2:0]                           grants,
  output logic [c_dom_nbits-1:0]               domain
);

  localparam int c_slot_nbits = (p_slot_cycles > 2) ? $clog2(p_slot_cycles) : 1;

  localparam logic [c_dest_nbits-1:0] c_id   = c_dest_nbits'(p_router_id);
  localparam logic [c_dest_nbits:0]   c_n    = (c_dest_nbits+1)'(p_num_routers);
  localparam logic [c_dest_nbits:0]   c_half = (c_dest_nbits+1)'(p_num_routers / 2);

  logic [c_slot_nbits-1:0] slot_cnt, slot_cnt_next;
  logic [c_dom_nbits-1:0]  cur_dom, cur_dom_next;
  logic [c_dom_nbits-1:0]  rr_ptr, rr_ptr_next;
  logic                    lock_vld, lock_vld_next;
  logic [c_dom_nbits-1:0]  lock_dom, lock_dom_next;

  logic [c_dom_nbits-1:0]  owner;
  logic [c_dest_nbits-1:0] owner_dest;
  logic                    fire;

  // Ring route: shortest direction east for up to half the ring, west otherwise.
  function automatic logic [2:0] route(input logic [c_dest_nbits-1:0] d);
    logic [c_dest_nbits:0] hops;
    hops = '0;
    if (d == c_id) begin
      route = p_default_reqs;
    end else begin
      if (d >= c_id) hops = {1'b0, d} - {1'b0, c_id};
      else           hops = {1'b0, d} + c_n - {1'b0, c_id};
      route = (hops <= c_half) ? 3'b100 : 3'b001;
    end
  endfunction

  function automatic logic [c_dom_nbits-1:0] dom_inc(input logic [c_dom_nbits-1:0] d);
    dom_inc = (int'(d) >= p_num_domains - 1) ? '0 : d + 1'b1;
  endfunction

  function automatic logic [c_dom_nbits-1:0] rr_pick(
    input logic [p_num_domains-1:0] v,
    input logic [c_dom_nbits-1:0]   ptr
  );
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < p_num_domains; i++) begin
      idx = int'(ptr) + i;
      if (idx >= p_num_domains) idx = idx - p_num_domains;
      if (!found && v[idx]) begin
        rr_pick = c_dom_nbits'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      cur_dom  <= '0;
      rr_ptr   <= '0;
      lock_vld <= 1'b0;
      lock_dom <= '0;
    end else begin
      slot_cnt <= slot_cnt_next;
      cur_dom  <= cur_dom_next;
      rr_ptr   <= rr_ptr_next;
      lock_vld <= lock_vld_next;
      lock_dom <= lock_dom_next;
    end
  end

  always_comb begin
    slot_cnt_next = slot_cnt;
    cur_dom_next  = cur_dom;
    rr_ptr_next   = rr_ptr;
    lock_vld_next = lock_vld;
    lock_dom_next = lock_dom;
    if (p_mode == 0) begin
      // Slot advance ignores traffic entirely so domains cannot perturb each other.
      if (int'(slot_cnt) >= p_slot_cycles - 1) begin
        slot_cnt_next = '0;
        cur_dom_next  = dom_inc(cur_dom);
      end else begin
        slot_cnt_next = slot_cnt + 1'b1;
      end
    end else begin
      if (lock_vld && !in_val[lock_dom]) begin
        lock_vld_next = 1'b0;
      end else if (fire) begin
        rr_ptr_next   = dom_inc(owner);
        lock_vld_next = 1'b0;
      end else if (!lock_vld && (|reqs)) begin
        lock_vld_next = 1'b1;
        lock_dom_next = owner;
      end
    end
  end

  always_comb begin
    owner = '0;
    if (p_mode == 0)   owner = cur_dom;
    else if (lock_vld) owner = lock_dom;
    else               owner = rr_pick(in_val, rr_ptr);
    // Ownership is pinned to domain 0 while reset is held, independent of mode.
    if (!reset) owner = '0;

    owner_dest = dest[int'(owner)*c_dest_nbits +: c_dest_nbits];
    reqs       = in_val[owner] ? route(owner_dest) : 3'b000;
    fire       = |(reqs & grants);
    in_rdy     = fire ? (p_num_domains'(1) << owner) : '0;
    domain     = owner;
  end

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_arb_tdm.sv
// Directed bench: one TDM instance (2 domains) and one round-robin instance
// (3 domains), both router id 2 on an 8-node ring.
module tb_plab4_net_router_input_ctrl_arb_tdm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // TDM instance
  logic       t_rst;
  logic [5:0] t_dest;
  logic [1:0] t_val, t_rdy;
  logic [2:0] t_reqs, t_grants;
  logic       t_dom;

  // Round-robin instance
  logic       r_rst;
  logic [8:0] r_dest;
  logic [2:0] r_val, r_rdy;
  logic [2:0] r_reqs, r_grants;
  logic [1:0] r_dom;

  plab4_net_router_input_ctrl_arb_tdm #(
    .p_router_id(2), .p_num_routers(8), .p_num_domains(2),
    .p_slot_cycles(4), .p_mode(0), .p_default_reqs(3'b010)
  ) u_tdm (
    .clk(clk), .reset(t_rst), .dest(t_dest), .in_val(t_val), .in_rdy(t_rdy),
    .reqs(t_reqs), .grants(t_grants), .domain(t_dom)
  );

  plab4_net_router_input_ctrl_arb_tdm #(
    .p_router_id(2), .p_num_routers(8), .p_num_domains(3),
    .p_slot_cycles(4), .p_mode(1), .p_default_reqs(3'b010)
  ) u_rr (
    .clk(clk), .reset(r_rst), .dest(r_dest), .in_val(r_val), .in_rdy(r_rdy),
    .reqs(r_reqs), .grants(r_grants), .domain(r_dom)
  );

  // Each pulse leaves the bench at cycle 0 (negedge + 1) after release.
  task automatic tdm_pulse_reset;
    @(negedge clk); t_rst = 1'b0; #1;
    @(negedge clk); t_rst = 1'b1; #1;
  endtask

  task automatic rr_pulse_reset;
    @(negedge clk); r_rst = 1'b0; #1;
    @(negedge clk); r_rst = 1'b1; #1;
  endtask

  task automatic test_reset;
    logic       exp_dom;
    logic [2:0] exp_reqs;
    t_rst = 1'b0; t_val = 2'b11; t_dest = {3'd7, 3'd5}; t_grants = 3'b000;
    repeat (2) @(negedge clk);
    #1;
    total++; if (t_reqs !== 3'b100) begin bad++; $display("FAIL reset_reqs got=%b exp=%b", t_reqs, 3'b100); end
    total++; if (t_dom !== 1'b0) begin bad++; $display("FAIL reset_domain got=%b exp=0", t_dom); end
    total++; if (t_rdy !== 2'b00) begin bad++; $display("FAIL reset_in_rdy got=%b exp=00", t_rdy); end
    @(negedge clk); t_rst = 1'b1; #1;
    for (int k = 0; k < 12; k++) begin
      exp_dom  = ((k / 4) % 2) == 1;
      exp_reqs = exp_dom ? 3'b001 : 3'b100;
      total++; if (t_dom !== exp_dom) begin bad++; $display("FAIL slot_seq_domain k=%0d got=%b exp=%b", k, t_dom, exp_dom); end
      total++; if (t_reqs !== exp_reqs) begin bad++; $display("FAIL slot_seq_reqs k=%0d got=%b exp=%b", k, t_reqs, exp_reqs); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_routing;
    logic [2:0] dl [7] = '{3'd2, 3'd5, 3'd6, 3'd7, 3'd0, 3'd3, 3'd1};
    logic [2:0] rl [7] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b100, 3'b001};
    t_rst = 1'b0; t_val = 2'b01; t_grants = 3'b000; t_dest = 6'd0;
    #1;
    for (int i = 0; i < 7; i++) begin
      t_dest[2:0] = dl[i];
      #1;
      total++; if (t_reqs !== rl[i]) begin bad++; $display("FAIL route dest=%0d got=%b exp=%b", dl[i], t_reqs, rl[i]); end
    end
    t_val = 2'b00; #1;
    total++; if (t_reqs !== 3'b000) begin bad++; $display("FAIL route_noval got=%b exp=000", t_reqs); end
    t_rst = 1'b1;
  endtask

  task automatic test_tdm_isolation;
    logic [1:0] exp_rdy;
    for (int v = 0; v < 2; v++) begin
      t_val = (v == 1) ? 2'b11 : 2'b10;
      t_dest = {3'd5, 3'd3}; t_grants = 3'b111;
      tdm_pulse_reset();
      for (int k = 0; k < 16; k++) begin
        exp_rdy = (((k / 4) % 2) == 1) ? 2'b10 : ((v == 1) ? 2'b01 : 2'b00);
        total++; if (t_rdy !== exp_rdy) begin bad++; $display("FAIL tdm_iso v=%0d k=%0d got=%b exp=%b", v, k, t_rdy, exp_rdy); end
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic test_tdm_drop;
    logic       in_d1;
    logic [1:0] exp_rdy;
    t_val = 2'b01; t_dest = {3'd0, 3'd5}; t_grants = 3'b000;
    tdm_pulse_reset();
    for (int k = 0; k < 9; k++) begin
      t_grants = (k == 8) ? 3'b100 : 3'b000;
      #1;
      in_d1   = (k >= 4) && (k < 8);
      exp_rdy = (k == 8) ? 2'b01 : 2'b00;
      total++; if (t_dom !== in_d1) begin bad++; $display("FAIL drop_domain k=%0d got=%b exp=%b", k, t_dom, in_d1); end
      total++; if (t_reqs !== (in_d1 ? 3'b000 : 3'b100)) begin bad++; $display("FAIL drop_reqs k=%0d got=%b", k, t_reqs); end
      total++; if (t_rdy !== exp_rdy) begin bad++; $display("FAIL drop_in_rdy k=%0d got=%b exp=%b", k, t_rdy, exp_rdy); end
      @(negedge clk); #1;
    end
    t_grants = 3'b000;
  endtask

  task automatic test_rr_lock;
    logic [2:0] gl [7] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b111, 3'b111};
    logic [1:0] dl [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [2:0] yl [7] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
    r_val = 3'b111; r_dest = {3'd5, 3'd5, 3'd5}; r_grants = 3'b000;
    rr_pulse_reset();
    for (int k = 0; k < 7; k++) begin
      r_grants = gl[k];
      #1;
      total++; if (r_dom !== dl[k]) begin bad++; $display("FAIL rr_domain k=%0d got=%0d exp=%0d", k, r_dom, dl[k]); end
      total++; if (r_rdy !== yl[k]) begin bad++; $display("FAIL rr_in_rdy k=%0d got=%b exp=%b", k, r_rdy, yl[k]); end
      @(negedge clk); #1;
    end
    r_grants = 3'b000;
  endtask

  task automatic test_rr_lock_drop;
    logic [2:0] vl [5] = '{3'b000, 3'b010, 3'b110, 3'b100, 3'b101};
    logic [1:0] dl [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [2:0] ql [5] = '{3'b000, 3'b100, 3'b100, 3'b000, 3'b100};
    r_val = 3'b000; r_dest = {3'd5, 3'd5, 3'd5}; r_grants = 3'b000;
    rr_pulse_reset();
    for (int k = 0; k < 5; k++) begin
      r_val = vl[k];
      #1;
      total++; if (r_dom !== dl[k]) begin bad++; $display("FAIL rrdrop_domain k=%0d got=%0d exp=%0d", k, r_dom, dl[k]); end
      total++; if (r_reqs !== ql[k]) begin bad++; $display("FAIL rrdrop_reqs k=%0d got=%b exp=%b", k, r_reqs, ql[k]); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_async_reset_lock;
    r_val = 3'b100; r_dest = {3'd5, 3'd5, 3'd5}; r_grants = 3'b000;
    rr_pulse_reset();
    @(negedge clk); #1;
    total++; if (r_dom !== 2'd2) begin bad++; $display("FAIL arst_locked got=%0d exp=2", r_dom); end
    #1; r_rst = 1'b0; r_grants = 3'b111;
    #1;
    total++; if (r_dom !== 2'd0) begin bad++; $display("FAIL arst_domain got=%0d exp=0", r_dom); end
    total++; if (r_reqs !== 3'b000) begin bad++; $display("FAIL arst_reqs got=%b exp=000", r_reqs); end
    total++; if (r_rdy !== 3'b000) begin bad++; $display("FAIL arst_in_rdy got=%b exp=000", r_rdy); end
    r_grants = 3'b000; r_val = 3'b011; r_rst = 1'b1;
    #1;
    total++; if (r_dom !== 2'd0) begin bad++; $display("FAIL arst_lock_cleared got=%0d exp=0", r_dom); end
    total++; if (r_reqs !== 3'b100) begin bad++; $display("FAIL arst_post_reqs got=%b exp=100", r_reqs); end
    @(negedge clk); r_grants = 3'b111; #1;
    total++; if (r_rdy !== 3'b001) begin bad++; $display("FAIL arst_post_fire got=%b exp=001", r_rdy); end
    r_grants = 3'b000;
  endtask

  initial begin
    t_rst = 1'b0; t_dest = '0; t_val = '0; t_grants = '0;
    r_rst = 1'b0; r_dest = '0; r_val = '0; r_grants = '0;
    test_reset();
    test_routing();
    test_tdm_isolation();
    test_tdm_drop();
    test_rr_lock();
    test_rr_lock_drop();
    test_async_reset_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
